// File: rtl/dkong3_sub_pkg.sv
// Shared definitions for the sound sub-CPU scheduler: default timing and ROM
// window parameters, the CPU identifiers and the arbiter state encoding.
package dkong3_sub_pkg;

  localparam int unsigned DEF_CLK_DIV  = 12;
  localparam logic [15:0] DEF_ROM_BASE = 16'hE000;
  localparam int unsigned DEF_ROM_AW   = 13;

  localparam logic SUB0 = 1'b0;
  localparam logic SUB1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK0 = 3'd1,
    ST_REQ0 = 3'd2,
    ST_CHK1 = 3'd3,
    ST_REQ1 = 3'd4,
    ST_DONE = 3'd5
  } sched_state_e;

endpackage

// File: rtl/dkong3_sub_phase_gen.sv
// CPU cycle phase generator: phase counter, PHI2, odd/even flag and the
// one-tick CPU clock enable. The counter parks on its last value until the
// owner reports cycle_done, which stretches the CPU cycle.
//   clk, rst     : clock, synchronous active-high reset
//   cycle_done   : work for this CPU cycle is complete
//   stall        : cycle is being held at its last phase
//   cnt          : current phase, 0..CLK_DIV-1
//   ce           : one-tick enable at the start of each CPU cycle
//   phi2         : high for the second half of the cycle and while stalled
//   odd_or_even  : toggles on every enable
module dkong3_sub_phase_gen
  import dkong3_sub_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  localparam int unsigned CNT_W  = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cycle_done,
  input  logic             stall,
  output logic [CNT_W-1:0] cnt,
  output logic             ce,
  output logic             phi2,
  output logic             odd_or_even
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] cnt_d;
  logic             ce_d;
  logic             odd_d;

  // Advance, wrap on completion, or hold at the last phase.
  always_comb begin
    cnt_d = CNT_W'(cnt + 1'b1);
    ce_d  = 1'b0;
    odd_d = odd_or_even;
    if (cnt == CNT_LAST) begin
      if (cycle_done) begin
        cnt_d = '0;
        ce_d  = 1'b1;
        odd_d = ~odd_or_even;
      end else begin
        cnt_d = cnt;
      end
    end
  end

  // PHI2 is computed from the next phase so it lines up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      ce          <= 1'b0;
      phi2        <= 1'b0;
      odd_or_even <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      ce          <= ce_d;
      phi2        <= (cnt_d >= CNT_HALF) || stall;
      odd_or_even <= odd_d;
    end
  end

endmodule

// File: rtl/dkong3_sub_sched.sv
// Cycle scheduler and program-ROM arbiter for the two sound sub-CPUs.
// Each CPU cycle, CPU0 then CPU1 get one slot on the shared ROM port; reads
// inside the ROM window are fetched and latched, everything else is skipped.
// A late ROM answer holds the cycle at its last phase until both slots finish.
//   I_SUBCLK, I_SUB_RESET          : clock, synchronous active-high reset
//   I_SUBn_ADDR / I_SUBn_RNW       : CPU address bus and read/write strobe
//   O_CPU_CE, O_PHI2, O_ODD_OR_EVEN: shared CPU/APU timing
//   O_ROM_REQ / O_ROM_ADDR         : ROM read request, {cpu_id, offset}
//   I_ROM_ACK / I_ROM_DATA         : one-tick answer with data
//   O_SUBn_ROM_DO                  : latched ROM byte per CPU
//   O_STALL                        : cycle held waiting for the ROM
module dkong3_sub_sched
  import dkong3_sub_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter logic [15:0] ROM_BASE = DEF_ROM_BASE,
  parameter int unsigned ROM_AW   = DEF_ROM_AW
) (
  input  logic              I_SUBCLK,
  input  logic              I_SUB_RESET,
  input  logic [15:0]       I_SUB0_ADDR,
  input  logic              I_SUB0_RNW,
  input  logic [15:0]       I_SUB1_ADDR,
  input  logic              I_SUB1_RNW,
  output logic              O_CPU_CE,
  output logic              O_PHI2,
  output logic              O_ODD_OR_EVEN,
  output logic              O_ROM_REQ,
  output logic [ROM_AW:0]   O_ROM_ADDR,
  input  logic              I_ROM_ACK,
  input  logic [7:0]        I_ROM_DATA,
  output logic [7:0]        O_SUB0_ROM_DO,
  output logic [7:0]        O_SUB1_ROM_DO,
  output logic              O_STALL
);

  localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             at_end;
  logic             cycle_done;
  logic             stall_c;
  logic             hit0, hit1;
  logic             rom_req_d;
  logic [ROM_AW:0]  rom_addr_d;
  logic [7:0]       do0_d, do1_d;

  assign at_end     = (cnt == CNT_LAST);
  assign cycle_done = (state_q == ST_DONE);
  assign stall_c    = at_end && !cycle_done;
  assign hit0       = I_SUB0_RNW && (I_SUB0_ADDR >= ROM_BASE);
  assign hit1       = I_SUB1_RNW && (I_SUB1_ADDR >= ROM_BASE);

  dkong3_sub_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk         (I_SUBCLK),
    .rst         (I_SUB_RESET),
    .cycle_done  (cycle_done),
    .stall       (stall_c),
    .cnt         (cnt),
    .ce          (O_CPU_CE),
    .phi2        (O_PHI2),
    .odd_or_even (O_ODD_OR_EVEN)
  );

  // Arbiter next state; the request line is high exactly while in a REQ state.
  always_comb begin
    state_d    = state_q;
    rom_req_d  = 1'b0;
    rom_addr_d = O_ROM_ADDR;
    do0_d      = O_SUB0_ROM_DO;
    do1_d      = O_SUB1_ROM_DO;
    case (state_q)
      ST_IDLE: begin
        if (cnt == '0) state_d = ST_CHK0;
      end
      ST_CHK0: begin
        if (hit0) begin
          state_d    = ST_REQ0;
          rom_req_d  = 1'b1;
          rom_addr_d = {SUB0, I_SUB0_ADDR[ROM_AW-1:0]};
        end else begin
          state_d = ST_CHK1;
        end
      end
      ST_REQ0: begin
        if (I_ROM_ACK) begin
          do0_d   = I_ROM_DATA;
          state_d = ST_CHK1;
        end else begin
          rom_req_d = 1'b1;
        end
      end
      ST_CHK1: begin
        if (hit1) begin
          state_d    = ST_REQ1;
          rom_req_d  = 1'b1;
          rom_addr_d = {SUB1, I_SUB1_ADDR[ROM_AW-1:0]};
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_REQ1: begin
        if (I_ROM_ACK) begin
          do1_d   = I_ROM_DATA;
          state_d = ST_DONE;
        end else begin
          rom_req_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (at_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge I_SUBCLK) begin
    if (I_SUB_RESET) begin
      state_q       <= ST_IDLE;
      O_ROM_REQ     <= 1'b0;
      O_ROM_ADDR    <= '0;
      O_SUB0_ROM_DO <= '0;
      O_SUB1_ROM_DO <= '0;
      O_STALL       <= 1'b0;
    end else begin
      state_q       <= state_d;
      O_ROM_REQ     <= rom_req_d;
      O_ROM_ADDR    <= rom_addr_d;
      O_SUB0_ROM_DO <= do0_d;
      O_SUB1_ROM_DO <= do1_d;
      O_STALL       <= stall_c;
    end
  end

endmodule

// File: tb/tb_dkong3_sub_sched.sv
// Self-checking bench for dkong3_sub_sched: directed table of CPU cycles,
// a reset-during-fetch sequence, then randomized cycles against a
// cycle-level timing model.
module tb_dkong3_sub_sched;
  import dkong3_sub_pkg::*;

  localparam int unsigned DIV       = 12;
  localparam int unsigned MAX_TICKS = 100;
  localparam int unsigned NVEC      = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a0, a1;
  logic        r0, r1;
  logic        ce, phi2, odd, rom_req, rom_ack, stall;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data, do0, do1;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_do0, exp_do1;
  logic        exp_odd;

  typedef struct {
    logic [15:0] a0;
    logic        r0;
    logic [15:0] a1;
    logic        r1;
    int          lat0;
    int          lat1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          exp_gap;
    logic        exp_stall;
    logic [7:0]  exp_do0;
    logic [7:0]  exp_do1;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  dkong3_sub_sched dut (
    .I_SUBCLK      (clk),
    .I_SUB_RESET   (rst),
    .I_SUB0_ADDR   (a0),
    .I_SUB0_RNW    (r0),
    .I_SUB1_ADDR   (a1),
    .I_SUB1_RNW    (r1),
    .O_CPU_CE      (ce),
    .O_PHI2        (phi2),
    .O_ODD_OR_EVEN (odd),
    .O_ROM_REQ     (rom_req),
    .O_ROM_ADDR    (rom_addr),
    .I_ROM_ACK     (rom_ack),
    .I_ROM_DATA    (rom_data),
    .O_SUB0_ROM_DO (do0),
    .O_SUB1_ROM_DO (do1),
    .O_STALL       (stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit in_rom(input logic [15:0] a, input logic r);
    return r && (a >= 16'hE000);
  endfunction

  // Cycle length from the slot budget: IDLE, CHK0, [REQ0 + latency], CHK1,
  // [REQ1 + latency] and then DONE; the cycle never ends before DIV ticks.
  function automatic int model_gap(input bit f0, input bit f1, input int l0, input int l1);
    int d;
    d = 3 + (f0 ? 1 + l0 : 0) + (f1 ? 1 + l1 : 0);
    return (d + 1 > int'(DIV)) ? d + 1 : int'(DIV);
  endfunction

  // Runs one CPU cycle starting on its cnt==0 tick and ending on the next CE
  // tick, acting as the ROM with the given per-CPU latencies.
  task automatic run_cycle(input logic [15:0] ca0, input logic cr0,
                           input logic [15:0] ca1, input logic cr1,
                           input int lat0, input int lat1,
                           input logic [7:0] dd0, input logic [7:0] dd1,
                           input bit stray, input int exp_gap, input bit exp_stall);
    logic [13:0] obs_addr[$];
    int          obs_tick[$];
    logic [13:0] want_addr[$];
    int          want_tick[$];
    logic [13:0] cur;
    int          t, wait_cnt, lat;
    bit          done, stall_seen, phi2_ok, addr_ok, f0, f1;
    a0 = ca0; r0 = cr0; a1 = ca1; r1 = cr1;
    f0 = in_rom(ca0, cr0);
    f1 = in_rom(ca1, cr1);
    if (f0) begin want_addr.push_back({1'b0, ca0[12:0]}); want_tick.push_back(2); end
    if (f1) begin want_addr.push_back({1'b1, ca1[12:0]}); want_tick.push_back(f0 ? 4 + lat0 : 3); end
    t = 0; wait_cnt = 0; done = 0; stall_seen = 0; phi2_ok = 1; addr_ok = 1; cur = '0;
    while (!done && t < int'(MAX_TICKS)) begin
      rom_ack  = 1'b0;
      rom_data = 8'h00;
      if (stray && t == 0) begin rom_ack = 1'b1; rom_data = 8'hEE; end
      if (phi2 !== (t >= int'(DIV / 2))) phi2_ok = 0;
      if (stall) stall_seen = 1;
      if (rom_req) begin
        if (wait_cnt == 0) begin
          cur = rom_addr;
          obs_addr.push_back(rom_addr);
          obs_tick.push_back(t);
        end else if (rom_addr !== cur) begin
          addr_ok = 0;
        end
        lat = rom_addr[13] ? lat1 : lat0;
        if (wait_cnt == lat) begin
          rom_ack  = 1'b1;
          rom_data = rom_addr[13] ? dd1 : dd0;
        end
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      @(posedge clk); #1;
      t++;
      if (ce) done = 1;
    end
    rom_ack = 1'b0;
    chk("ce_within_budget", 32'(done), 32'd1);
    chk("cycle_gap", 32'(t), 32'(exp_gap));
    chk("stall_seen", 32'(stall_seen), 32'(exp_stall));
    chk("phi2_phase", 32'(phi2_ok), 32'd1);
    chk("rom_addr_stable", 32'(addr_ok), 32'd1);
    chk("req_count", 32'(obs_addr.size()), 32'(want_addr.size()));
    for (int k = 0; k < want_addr.size() && k < obs_addr.size(); k++) begin
      chk("req_addr", 32'(obs_addr[k]), 32'(want_addr[k]));
      chk("req_tick", 32'(obs_tick[k]), 32'(want_tick[k]));
    end
    exp_odd = ~exp_odd;
    chk("odd_or_even", 32'(odd), 32'(exp_odd));
    if (f0) exp_do0 = dd0;
    if (f1) exp_do1 = dd1;
  endtask

  initial begin
    logic [15:0] ra0, ra1;
    logic        rr0, rr1;
    int          rl0, rl1, n;
    logic [7:0]  rd0, rd1;
    bit          in_req1;

    vecs[0] = '{16'hFFFC, 1'b1, 16'hFFFE, 1'b1, 1, 1,  8'h12, 8'h34, 12, 1'b0, 8'h12, 8'h34};
    vecs[1] = '{16'hE010, 1'b1, 16'hE123, 1'b1, 1, 1,  8'hA5, 8'h5A, 12, 1'b0, 8'hA5, 8'h5A};
    vecs[2] = '{16'hE000, 1'b0, 16'h4015, 1'b1, 1, 1,  8'hEE, 8'hEE, 12, 1'b0, 8'hA5, 8'h5A};
    vecs[3] = '{16'hDFFF, 1'b1, 16'hE000, 1'b1, 0, 0,  8'h11, 8'h22, 12, 1'b0, 8'hA5, 8'h22};
    vecs[4] = '{16'hE000, 1'b1, 16'hFFFF, 1'b1, 3, 3,  8'h66, 8'h77, 12, 1'b0, 8'h66, 8'h77};
    vecs[5] = '{16'hE000, 1'b1, 16'hE001, 1'b1, 3, 4,  8'h88, 8'h99, 13, 1'b1, 8'h88, 8'h99};
    vecs[6] = '{16'hE555, 1'b1, 16'hF0F0, 1'b1, 1, 15, 8'hC3, 8'h3C, 22, 1'b1, 8'hC3, 8'h3C};
    vecs[7] = '{16'hE000, 1'b0, 16'hE000, 1'b0, 2, 2,  8'h01, 8'h02, 12, 1'b0, 8'hC3, 8'h3C};
    vecs[8] = '{16'h0000, 1'b1, 16'hE000, 1'b1, 0, 0,  8'h5F, 8'hF5, 12, 1'b0, 8'hC3, 8'hF5};

    rst = 1'b1; a0 = '0; a1 = '0; r0 = 1'b0; r1 = 1'b0; rom_ack = 1'b0; rom_data = '0;
    exp_do0 = '0; exp_do1 = '0; exp_odd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_phi2", 32'(phi2), 32'd0);
    chk("rst_odd", 32'(odd), 32'd0);
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_do0", 32'(do0), 32'd0);
    chk("rst_do1", 32'(do1), 32'd0);
    rst = 1'b0;

    // Directed cycles, back to back from reset release.
    for (int i = 0; i < int'(NVEC); i++) begin
      run_cycle(vecs[i].a0, vecs[i].r0, vecs[i].a1, vecs[i].r1, vecs[i].lat0, vecs[i].lat1,
                vecs[i].d0, vecs[i].d1, 1'b0, vecs[i].exp_gap, vecs[i].exp_stall);
      chk("vec_do0", 32'(do0), 32'(vecs[i].exp_do0));
      chk("vec_do1", 32'(do1), 32'(vecs[i].exp_do1));
    end

    // Reset while CPU1's request is outstanding.
    a0 = 16'hE000; r0 = 1'b1; a1 = 16'hE100; r1 = 1'b1;
    n = 0; in_req1 = 0;
    while (!in_req1 && n < 40) begin
      rom_ack = 1'b0;
      if (rom_req && !rom_addr[13]) begin rom_ack = 1'b1; rom_data = 8'h42; end
      if (rom_req && rom_addr[13]) in_req1 = 1;
      else begin @(posedge clk); #1; n++; end
    end
    chk("reached_req1", 32'(in_req1), 32'd1);
    rom_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_req", 32'(rom_req), 32'd0);
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    chk("midrst_do0", 32'(do0), 32'd0);
    chk("midrst_do1", 32'(do1), 32'd0);
    chk("midrst_odd", 32'(odd), 32'd0);
    exp_do0 = '0; exp_do1 = '0; exp_odd = 1'b0;
    run_cycle(16'hE000, 1'b0, 16'hE100, 1'b1, 0, 1, 8'h77, 8'h3C, 1'b1, 12, 1'b0);
    chk("stray_do0", 32'(do0), 32'd0);
    chk("stray_do1", 32'(do1), 32'h3C);

    // Randomized cycles against the timing model.
    for (int i = 0; i < 60; i++) begin
      ra0 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'hE000 | 16'($urandom_range(0, 8191)));
      ra1 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'hE000 | 16'($urandom_range(0, 8191)));
      rr0 = ($urandom_range(0, 4) != 0);
      rr1 = ($urandom_range(0, 4) != 0);
      rl0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 15)) : int'($urandom_range(0, 5));
      rl1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 15)) : int'($urandom_range(0, 5));
      rd0 = 8'($urandom);
      rd1 = 8'($urandom);
      n = model_gap(in_rom(ra0, rr0), in_rom(ra1, rr1), rl0, rl1);
      run_cycle(ra0, rr0, ra1, rr1, rl0, rl1, rd0, rd1, 1'b0, n, n > int'(DIV));
      chk("rand_do0", 32'(do0), 32'(exp_do0));
      chk("rand_do1", 32'(do1), 32'(exp_do1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
